// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encodings, owner identities
// and the default memory word-address width.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 10;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-requester round-robin pick. Purely combinational: on a tie the requester
// that did not own the previous grant wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic elig_cpu,
    input  logic elig_dbg,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = elig_cpu | elig_dbg;
        if (elig_cpu && elig_dbg)
            grant_owner = (last_owner == OWN_DBG) ? OWN_CPU : OWN_DBG;
        else if (elig_dbg)
            grant_owner = OWN_DBG;
        else
            grant_owner = OWN_CPU;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port instruction/data memory between the CPU control unit and
// the debug/loader port; one registered access per grant, one-cycle acknowledge.
//
//   state  | meaning
//   IDLE   | no access in flight, arbitrate every cycle
//   ACCESS | latched request drives the memory strobes
//   RESP   | owner's ack pulses; the other side may be granted back-to-back
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    input  logic        dbg_lock,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    logic        owner_q;
    logic        last_owner;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        in_range;

    logic        elig_cpu;
    logic        elig_dbg;
    logic        grant_valid;
    logic        grant_owner;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // The responding owner still holds its req during RESP; it must not re-win.
    always_comb begin
        elig_cpu = cpu_req & ~dbg_lock;
        elig_dbg = dbg_req;
        if (state == RESP) begin
            if (owner_q == OWN_CPU)
                elig_cpu = 1'b0;
            else
                elig_dbg = 1'b0;
        end
    end

    rr_arb2 u_rr (
        .elig_cpu    (elig_cpu),
        .elig_dbg    (elig_dbg),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign sel_we    = (grant_owner == OWN_DBG) ? dbg_we    : cpu_we;
    assign sel_addr  = (grant_owner == OWN_DBG) ? dbg_addr  : cpu_addr;
    assign sel_wdata = (grant_owner == OWN_DBG) ? dbg_wdata : cpu_wdata;

    assign in_range = (addr_q[31:ADDR_W] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_q    <= OWN_CPU;
            last_owner <= OWN_DBG;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            case (state)
                ACCESS: begin
                    err_q <= ~in_range;
                    if (!we_q) begin
                        if (owner_q == OWN_DBG)
                            dbg_rdata <= in_range ? mem_rdata : '0;
                        else
                            cpu_rdata <= in_range ? mem_rdata : '0;
                    end
                    state <= RESP;
                end
                default: begin
                    if (grant_valid) begin
                        state      <= ACCESS;
                        owner_q    <= grant_owner;
                        last_owner <= grant_owner;
                        we_q       <= sel_we;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state == ACCESS) & we_q & in_range;
    assign mem_re    = (state == ACCESS) & ~we_q & in_range;

    assign cpu_ack = (state == RESP) & (owner_q == OWN_CPU);
    assign dbg_ack = (state == RESP) & (owner_q == OWN_DBG);
    assign cpu_err = cpu_ack & err_q;
    assign dbg_err = dbg_ack & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack, dbg_err, dbg_lock;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        init_mem;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .dbg_lock(dbg_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    // Memory instance stand-in: combinational read, write on the rising edge.
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: one transaction in flight at most; a grant is followed by
    // its strobe cycle and then its acknowledge cycle.
    logic [31:0] gold [0:1023];
    bit          m_busy, m_resp, m_owner, m_last, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] exp_rdata [2];
    bit          exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_resp = 1'b0;
        m_last = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_err = 1'b0;
    endtask

    task automatic model_edge(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                              input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                              input bit lk);
        bit want_cpu, want_dbg, win;
        if (m_busy && !m_resp) begin
            if (m_addr < 32'd1024) begin
                if (m_we) gold[m_addr[9:0]] = m_wdata;
                else      exp_rdata[m_owner] = gold[m_addr[9:0]];
            end else if (!m_we) begin
                exp_rdata[m_owner] = 32'd0;
            end
            exp_err = (m_addr >= 32'd1024);
            m_resp = 1'b1;
        end else begin
            want_cpu = cr && !lk && !(m_busy && m_owner == 1'b0);
            want_dbg = dr && !(m_busy && m_owner == 1'b1);
            m_busy = 1'b0;
            m_resp = 1'b0;
            if (want_cpu || want_dbg) begin
                win     = (want_cpu && want_dbg) ? !m_last : want_dbg;
                m_busy  = 1'b1;
                m_owner = win;
                m_last  = win;
                m_we    = win ? dw : cw;
                m_addr  = win ? da : ca;
                m_wdata = win ? dd : cd;
            end
        end
    endtask

    task automatic compare_outputs();
        bit acc, inr, resp;
        acc  = m_busy && !m_resp;
        resp = m_busy && m_resp;
        inr  = (m_addr < 32'd1024);
        chk("cpu_ack", 32'(cpu_ack), 32'(resp && !m_owner));
        chk("dbg_ack", 32'(dbg_ack), 32'(resp && m_owner));
        chk("mem_we", 32'(mem_we), 32'(acc && m_we && inr));
        chk("mem_re", 32'(mem_re), 32'(acc && !m_we && inr));
        if (acc) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("cpu_rdata", cpu_rdata, exp_rdata[0]);
        chk("dbg_rdata", dbg_rdata, exp_rdata[1]);
        if (resp && !m_owner) chk("cpu_err", 32'(cpu_err), 32'(exp_err));
        if (resp && m_owner)  chk("dbg_err", 32'(dbg_err), 32'(exp_err));
    endtask

    // One clock: update the model at the edge, compare just after it, return at the
    // falling edge where the caller drives the next inputs.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(cpu_req, cpu_we, cpu_addr, cpu_wdata,
                        dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock);
        #1;
        if (!rst) compare_outputs();
        @(negedge clk);
    endtask

    task automatic set_port(input bit p, input bit req, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        dbg_lock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic access(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output bit err, output int lat, output int we_cnt);
        bit got;
        got = 1'b0; lat = 0; we_cnt = 0; rdata = '0; err = 1'b0;
        set_port(p, 1'b1, we, addr, wdata);
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            lat++;
            if (mem_we) we_cnt++;
            if (p ? dbg_ack : cpu_ack) begin
                got   = 1'b1;
                rdata = p ? dbg_rdata : cpu_rdata;
                err   = p ? dbg_err : cpu_err;
            end
        end
        chk("access_ack_seen", 32'(got), 32'd1);
        tick();
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic random_req(input bit p);
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'h400 + $urandom_range(0, 255);
        else if (r == 1) a = $urandom;
        else             a = $urandom_range(0, 15);
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    logic [31:0] rd;
    bit          er;
    int          lat, wec, cnt_c, cnt_d, last_t;
    bit          got;
    bit          after_ack [2];
    int          order [$];

    initial begin
        for (int i = 0; i < 1024; i++) gold[i] = '0;
        model_reset();
        init_mem = 1'b1;
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        dbg_lock = 1'b0;
        tick();
        init_mem = 1'b0;
        tick();

        // reset values
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", 32'({cpu_ack, dbg_ack, cpu_err, dbg_err}), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        rst = 1'b0;

        // CPU write then read back
        access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, rd, er, lat, wec);
        chk("wr5_latency", 32'(lat), 32'd2);
        chk("wr5_we_cycles", 32'(wec), 32'd1);
        chk("wr5_err", 32'(er), 32'd0);
        access(1'b0, 1'b0, 32'd5, 32'd0, rd, er, lat, wec);
        chk("rd5_data", rd, 32'hDEADBEEF);
        chk("rd5_err", 32'(er), 32'd0);
        chk("rd5_we_cycles", 32'(wec), 32'd0);

        // both requesting continuously from reset: alternate CPU, DBG, ...
        do_reset();
        set_port(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, 32'd2, 32'd0);
        order.delete();
        last_t = -1;
        for (int t = 0; t < 16; t++) begin
            tick();
            chk("both_acked", 32'(cpu_ack & dbg_ack), 32'd0);
            if (cpu_ack || dbg_ack) begin
                order.push_back(dbg_ack ? 1 : 0);
                if (last_t >= 0) chk("ack_gap", 32'(t - last_t), 32'd2);
                last_t = t;
            end
        end
        chk("rr_ack_count", 32'(order.size()), 32'd8);
        if (order.size() >= 4) begin
            chk("rr_order0", 32'(order[0]), 32'd0);
            chk("rr_order1", 32'(order[1]), 32'd1);
            chk("rr_order2", 32'(order[2]), 32'd0);
            chk("rr_order3", 32'(order[3]), 32'd1);
        end

        // lock: only DBG served, then CPU picks up once lock drops
        do_reset();
        dbg_lock = 1'b1;
        set_port(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, 32'd4, 32'd0);
        cnt_c = 0; cnt_d = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (cpu_ack) cnt_c++;
            if (dbg_ack) cnt_d++;
        end
        chk("lock_cpu_acks", 32'(cnt_c), 32'd0);
        chk("lock_dbg_acks", 32'(cnt_d), 32'd4);
        dbg_lock = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 4 && !got; t++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        chk("unlock_cpu_ack", 32'(got), 32'd1);

        // out-of-range accesses from the loader
        do_reset();
        access(1'b1, 1'b0, 32'd5, 32'd0, rd, er, lat, wec);
        chk("dbg_rd5", rd, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, rd, er, lat, wec);
        chk("oob_wr_we_cycles", 32'(wec), 32'd0);
        chk("oob_wr_err", 32'(er), 32'd1);
        access(1'b1, 1'b0, 32'h400, 32'd0, rd, er, lat, wec);
        chk("oob_rd_data", rd, 32'd0);
        chk("oob_rd_err", 32'(er), 32'd1);

        // reset in the middle of a write strobe
        access(1'b0, 1'b1, 32'd7, 32'h11, rd, er, lat, wec);
        access(1'b0, 1'b0, 32'd5, 32'd0, rd, er, lat, wec);
        set_port(1'b0, 1'b1, 1'b1, 32'd7, 32'h99);
        tick();
        chk("mid_access_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_we_drop", 32'(mem_we), 32'd0);
        chk("rst_no_ack", 32'(cpu_ack), 32'd0);
        chk("rst_addr_clr", mem_addr, 32'd0);
        chk("rst_rdata_clr", cpu_rdata, 32'd0);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        tick();
        chk("addr7_kept", mem[7], 32'h11);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) tick();

        // lock raised while a CPU access is already in flight
        set_port(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        tick();
        dbg_lock = 1'b1;
        set_port(1'b1, 1'b1, 1'b0, 32'd6, 32'd0);
        got = 1'b0;
        for (int t = 0; t < 3 && !got; t++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        chk("inflight_cpu_ack", 32'(got), 32'd1);
        cnt_c = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (cpu_ack) cnt_c++;
        end
        chk("post_lock_cpu_acks", 32'(cnt_c), 32'd0);

        // randomized traffic against the model
        do_reset();
        after_ack[0] = 1'b0;
        after_ack[1] = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (m_busy && m_resp && m_owner == 1'(p)) begin
                    after_ack[p] = 1'b1;
                end else if (after_ack[p]) begin
                    after_ack[p] = 1'b0;
                    if ($urandom_range(0, 1) == 1) random_req(1'(p));
                    else set_port(1'(p), 1'b0, 1'b0, '0, '0);
                end else if (!(p == 1 ? dbg_req : cpu_req) && $urandom_range(0, 3) == 0) begin
                    random_req(1'(p));
                end
            end
            if ($urandom_range(0, 49) == 0) dbg_lock = ~dbg_lock;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
